// File: rtl/usb_pack_pkg.sv
// usb_pack_pkg: definitions shared by the uplink framer (usb_pack_tx) and
// the downlink cache parser, so both sides agree on the packet header.
//
// Header word layout: {HDR_MARK_HI, type_field[15:0], HDR_MARK_LO}
//   type 1 -> 16'h0000, 2 -> 16'h000a, 3 -> 16'h0aaa,
//   type 4 -> 16'haaaa, 5 -> 16'h00aa
package usb_pack_pkg;

  // Packet type codes carried on req_type.
  typedef enum logic [2:0] {
    PT_CA = 3'd1,
    PT_2  = 3'd2,
    PT_3  = 3'd3,
    PT_4  = 3'd4,
    PT_5  = 3'd5
  } pkt_type_e;

  // 16-bit header field for each packet type.
  localparam logic [15:0] HF_CA = 16'h0000;
  localparam logic [15:0] HF_2  = 16'h000a;
  localparam logic [15:0] HF_3  = 16'h0aaa;
  localparam logic [15:0] HF_4  = 16'haaaa;
  localparam logic [15:0] HF_5  = 16'h00aa;

  // Framing marks; HDR_MASK selects the bytes that identify a header word.
  localparam logic [7:0]  HDR_MARK_HI = 8'hFF;
  localparam logic [7:0]  HDR_MARK_LO = 8'hAA;
  localparam logic [31:0] HDR_MASK    = 32'hFF0000FF;

  // Framer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_END,
    ST_GAP
  } state_e;

  // True for the five defined packet types.
  function automatic logic type_valid(input logic [2:0] t);
    return (t >= PT_CA) && (t <= PT_5);
  endfunction

  // Header field lookup; undefined types map to zero (never framed).
  function automatic logic [15:0] type_field(input logic [2:0] t);
    logic [15:0] f;
    case (t)
      PT_CA:   f = HF_CA;
      PT_2:    f = HF_2;
      PT_3:    f = HF_3;
      PT_4:    f = HF_4;
      PT_5:    f = HF_5;
      default: f = 16'h0000;
    endcase
    return f;
  endfunction

  // Complete 32-bit header word for a packet type.
  function automatic logic [31:0] build_header(input logic [2:0] t);
    return {HDR_MARK_HI, type_field(t), HDR_MARK_LO};
  endfunction

  // Used by the downlink parser to spot a header word in the stream.
  function automatic logic is_header(input logic [31:0] w);
    return (w & HDR_MASK) == {HDR_MARK_HI, 16'h0000, HDR_MARK_LO};
  endfunction

endpackage

// File: rtl/usb_pack_tx.sv
// usb_pack_tx: uplink packet framer, FPGA -> FX3 slave FIFO.
//
// Takes a packet request (type, length) and a 32-bit payload stream, and
// writes one header word, then the payload words, then (optionally) a
// one-cycle PKTEND strobe, followed by a single turnaround cycle.
//
// Ports:
//   wrclock        in   FX3 PCLK, the only clock
//   rst_n          in   synchronous active-low reset
//   req_valid      in   packet request present
//   req_ready      out  high in IDLE only
//   req_type       in   [2:0] packet type, 1..5
//   req_len        in   [8:0] payload words, 1..MAX_LEN
//   src_data       in   [31:0] payload word
//   src_valid      in   payload word present
//   src_ready      out  payload word consumed on src_valid && src_ready
//   USB3_FLAGB     in   FX3 write FIFO has space
//   USB3_DATA      out  [31:0] write data (registered)
//   USB3_SLWR_N    out  write strobe, active-low (registered)
//   USB3_PKTEND_N  out  packet-end strobe, active-low (registered)
//   busy           out  not in IDLE
//   err            out  one-cycle pulse when a request is rejected
//
// Payload words are not escaped: the producer must not start a payload with
// a word that looks like a header (see is_header in the package).
module usb_pack_tx
  import usb_pack_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 256,
  parameter bit          PKTEND_EN = 1'b1
) (
  input  logic        wrclock,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [8:0]  req_len,
  input  logic [31:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic        USB3_FLAGB,
  output logic [31:0] USB3_DATA,
  output logic        USB3_SLWR_N,
  output logic        USB3_PKTEND_N,
  output logic        busy,
  output logic        err
);

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        slwr_n_q, slwr_n_d;
  logic        pktend_n_q, pktend_n_d;
  logic        err_q, err_d;
  logic [2:0]  type_q, type_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        req_ok;

  // A request is framed only if both its type and its length are legal.
  assign req_ok = type_valid(req_type) && (req_len != 9'd0) &&
                  (32'(req_len) <= MAX_LEN);

  assign req_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign USB3_DATA     = data_q;
  assign USB3_SLWR_N   = slwr_n_q;
  assign USB3_PKTEND_N = pktend_n_q;
  assign err           = err_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    data_d     = data_q;
    slwr_n_d   = 1'b1;
    pktend_n_d = 1'b1;
    err_d      = 1'b0;
    type_d     = type_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    src_ready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_ok) begin
            type_d  = req_type;
            len_d   = req_len;
            cnt_d   = 9'd0;
            state_d = ST_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_HDR: begin
        // The header waits for FIFO space for as long as it takes.
        if (USB3_FLAGB) begin
          data_d   = build_header(type_q);
          slwr_n_d = 1'b0;
          state_d  = ST_PAY;
        end
      end

      ST_PAY: begin
        // FLAGB gates src_ready directly, so a word is never taken in a
        // cycle where the FIFO has no room for it.
        src_ready = USB3_FLAGB && (cnt_q < len_q);
        if (src_ready && src_valid) begin
          data_d   = src_data;
          slwr_n_d = 1'b0;
          cnt_d    = cnt_q + 9'd1;
          if (cnt_q + 9'd1 == len_q) state_d = ST_END;
        end
      end

      ST_END: begin
        pktend_n_d = ~PKTEND_EN;
        state_d    = ST_GAP;
      end

      ST_GAP: begin
        // One cycle with all strobes high for FX3 bus turnaround.
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wrclock) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= 32'h0;
      slwr_n_q   <= 1'b1;
      pktend_n_q <= 1'b1;
      err_q      <= 1'b0;
      type_q     <= 3'd0;
      len_q      <= 9'd0;
      cnt_q      <= 9'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      data_q     <= data_d;
      slwr_n_q   <= slwr_n_d;
      pktend_n_q <= pktend_n_d;
      err_q      <= err_d;
      type_q     <= type_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_usb_pack_tx.sv
// tb_usb_pack_tx: self-checking bench for usb_pack_tx.
//
// The model is a queue of expected FIFO writes built when a request is seen
// accepted: the header word from the type table, then the next req_len words
// offered by the producer. A per-cycle compare process checks every write,
// the PKTEND strobe (exactly the cycle after a packet's last word) and the
// err pulse. Directed tests add literal values and cycle positions.
module tb_usb_pack_tx;

  logic        wrclock = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [8:0]  req_len;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        USB3_FLAGB;
  logic [31:0] USB3_DATA;
  logic        USB3_SLWR_N;
  logic        USB3_PKTEND_N;
  logic        busy;
  logic        err;

  always #5 wrclock = ~wrclock;

  usb_pack_tx #(.MAX_LEN(256), .PKTEND_EN(1'b1)) dut (
    .wrclock       (wrclock),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_type      (req_type),
    .req_len       (req_len),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .USB3_FLAGB    (USB3_FLAGB),
    .USB3_DATA     (USB3_DATA),
    .USB3_SLWR_N   (USB3_SLWR_N),
    .USB3_PKTEND_N (USB3_PKTEND_N),
    .busy          (busy),
    .err           (err)
  );

  typedef struct {
    logic [31:0] data;
    bit          last;
  } wr_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  mon_on  = 1'b0;
  bit  hs      = 1'b0;
  bit  pend_pe = 1'b0;

  logic [31:0] src_q[$];    // words the producer still has to offer
  logic [31:0] mdl_src[$];  // same words, consumed by the model at accept
  wr_t         exp_q[$];    // expected FIFO writes, in order
  int          exp_err[$];  // cycles in which err must be high

  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          pe_cyc[$];
  int          err_cyc[$];
  int          acc_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Header words written out in full from the type table.
  function automatic logic [31:0] hdr_of(input logic [2:0] t);
    case (t)
      3'd1:    return 32'hFF0000AA;
      3'd2:    return 32'hFF000AAA;
      3'd3:    return 32'hFF0AAAAA;
      3'd4:    return 32'hFFAAAAAA;
      3'd5:    return 32'hFF00AAAA;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int wc(input int i);
    return (i >= 0 && i < wr_cyc.size()) ? wr_cyc[i] : -1;
  endfunction

  function automatic logic [31:0] wd(input int i);
    return (i >= 0 && i < wr_data.size()) ? wr_data[i] : 32'hDEADDEAD;
  endfunction

  always @(posedge wrclock) cyc++;

  // Producer: offers src_q in order, drops a word after each handshake.
  initial begin
    src_valid = 1'b0;
    src_data  = 32'h0;
    forever begin
      @(posedge wrclock);
      #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      src_valid = (src_q.size() > 0);
      src_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
    end
  end

  // Per-cycle compare process plus model update on request accept.
  always @(negedge wrclock) begin
    bit   next_pe;
    bit   err_exp;
    wr_t  e;
    logic [31:0] d;
    hs = (src_valid === 1'b1) && (src_ready === 1'b1);
    if (mon_on) begin
      next_pe = 1'b0;
      if (USB3_SLWR_N === 1'b0) begin
        wr_data.push_back(USB3_DATA);
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_write", USB3_DATA, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          check("write_data", USB3_DATA, e.data);
          next_pe = e.last;
        end
      end
      check_bit("pktend_n", USB3_PKTEND_N, pend_pe ? 1'b0 : 1'b1);
      if (USB3_PKTEND_N === 1'b0) pe_cyc.push_back(cyc);
      pend_pe = next_pe;

      if (err === 1'b1) err_cyc.push_back(cyc);
      err_exp = (exp_err.size() > 0) && (exp_err[0] == cyc);
      check_bit("err", err, err_exp);
      if (err_exp) void'(exp_err.pop_front());

      if (req_valid === 1'b1 && req_ready === 1'b1) begin
        acc_q.push_back(cyc + 1);
        if (req_type >= 3'd1 && req_type <= 3'd5 &&
            req_len >= 9'd1 && req_len <= 9'd256) begin
          exp_q.push_back('{data: hdr_of(req_type), last: 1'b0});
          for (int i = 0; i < int'(req_len); i++) begin
            d = (mdl_src.size() > 0) ? mdl_src.pop_front() : 32'hDEADBEEF;
            exp_q.push_back('{data: d, last: (i == int'(req_len) - 1)});
          end
        end else begin
          exp_err.push_back(cyc + 1);
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    src_q.push_back(w);
    mdl_src.push_back(w);
  endtask

  task automatic clear_logs();
    wr_data.delete();
    wr_cyc.delete();
    pe_cyc.delete();
    err_cyc.delete();
  endtask

  // Presents one request for one cycle; acc is the accepting edge.
  task automatic send_req(input logic [2:0] t, input logic [8:0] l,
                          output int acc);
    int base;
    base = acc_q.size();
    @(posedge wrclock);
    #1;
    req_type  = t;
    req_len   = l;
    req_valid = 1'b1;
    @(posedge wrclock);
    #1;
    req_valid = 1'b0;
    acc = (acc_q.size() > base) ? acc_q[base] : -1;
    check("req_taken", acc_q.size() - base, 32'd1);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    @(negedge wrclock);
    while ((busy !== 1'b0 || exp_q.size() != 0 || pend_pe) && n < bound) begin
      @(negedge wrclock);
      n++;
    end
    check_bit("done_in_time", n < bound, 1'b1);
    @(negedge wrclock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    int n;
    logic [2:0] bad_t [5];
    logic [8:0] bad_l [5];
    bad_t = '{3'd0, 3'd6, 3'd1, 3'd1, 3'd7};
    bad_l = '{9'd1, 9'd1, 9'd0, 9'd257, 9'd3};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_type   = 3'd0;
    req_len    = 9'd0;
    USB3_FLAGB = 1'b1;

    // Reset values.
    repeat (3) @(posedge wrclock);
    @(negedge wrclock);
    check("rst_data", USB3_DATA, 32'h0);
    check_bit("rst_slwr_n", USB3_SLWR_N, 1'b1);
    check_bit("rst_pktend_n", USB3_PKTEND_N, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_req_ready", req_ready, 1'b1);
    check_bit("rst_src_ready", src_ready, 1'b0);
    check_bit("rst_err", err, 1'b0);
    @(posedge wrclock);
    #1;
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Type 1, len 4: five back-to-back writes, then PKTEND.
    clear_logs();
    push_word(32'h11111111);
    push_word(32'h22222222);
    push_word(32'h33333333);
    push_word(32'h44444444);
    send_req(3'd1, 9'd4, acc);
    wait_done(50);
    check("t1_writes", wr_data.size(), 32'd5);
    check("t1_hdr", wd(0), 32'hFF0000AA);
    check("t1_w1", wd(1), 32'h11111111);
    check("t1_w4", wd(4), 32'h44444444);
    check("t1_hdr_cycle", wc(0), acc + 1);
    check("t1_first_pay_cycle", wc(1), acc + 2);
    check("t1_consecutive", wc(4) - wc(0), 32'd4);
    check("t1_pktend_count", pe_cyc.size(), 32'd1);
    check("t1_pktend_cycle", (pe_cyc.size() > 0) ? pe_cyc[0] : -1, wc(4) + 1);
    check_bit("t1_idle_ready", req_ready, 1'b1);

    // Type 4 and type 5 headers.
    clear_logs();
    push_word(32'h000000A0);
    push_word(32'h000000A1);
    send_req(3'd4, 9'd2, acc);
    wait_done(50);
    check("t4_hdr", wd(0), 32'hFFAAAAAA);
    check("t4_writes", wr_data.size(), 32'd3);
    clear_logs();
    push_word(32'h000000B0);
    send_req(3'd5, 9'd1, acc);
    wait_done(50);
    check("t5_hdr", wd(0), 32'hFF00AAAA);
    check("t5_pay", wd(1), 32'h000000B0);

    // Rejected requests: err pulse, no strobe, still ready.
    for (int k = 0; k < 5; k++) begin
      clear_logs();
      send_req(bad_t[k], bad_l[k], acc);
      wait_done(20);
      check("bad_err_count", err_cyc.size(), 32'd1);
      check("bad_err_cycle", (err_cyc.size() > 0) ? err_cyc[0] : -1, acc);
      check("bad_no_write", wr_data.size(), 32'd0);
      check_bit("bad_ready", req_ready, 1'b1);
      check_bit("bad_busy", busy, 1'b0);
    end

    // FLAGB low for 3 cycles right after the 2nd payload word.
    clear_logs();
    for (int i = 0; i < 5; i++) push_word(32'hC0000000 + i);
    send_req(3'd2, 9'd5, acc);
    repeat (3) @(posedge wrclock);
    #1;
    USB3_FLAGB = 1'b0;
    repeat (3) @(posedge wrclock);
    #1;
    USB3_FLAGB = 1'b1;
    wait_done(50);
    check("fb_writes", wr_data.size(), 32'd6);
    check("fb_hdr", wd(0), 32'hFF000AAA);
    check("fb_w2_cycle", wc(2), acc + 3);
    check("fb_w3_cycle", wc(3), acc + 7);
    check("fb_w3_data", wd(3), 32'hC0000002);
    check("fb_w5_cycle", wc(5), acc + 9);

    // Reset while word 3 of 8 is on the bus.
    clear_logs();
    for (int i = 0; i < 8; i++) push_word(32'hD0000000 + i);
    send_req(3'd3, 9'd8, acc);
    repeat (4) @(posedge wrclock);
    #1;
    rst_n = 1'b0;
    @(negedge wrclock);
    @(negedge wrclock);
    check_bit("mid_rst_slwr_n", USB3_SLWR_N, 1'b1);
    check_bit("mid_rst_pktend_n", USB3_PKTEND_N, 1'b1);
    check_bit("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", USB3_DATA, 32'h0);
    check("mid_rst_writes", wr_data.size(), 32'd4);
    check("mid_rst_w3", wd(3), 32'hD0000002);
    @(posedge wrclock);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    mdl_src.delete();
    src_q.delete();
    repeat (2) @(posedge wrclock);
    clear_logs();
    push_word(32'hE0000000);
    send_req(3'd1, 9'd1, acc);
    wait_done(50);
    check("post_rst_hdr", wd(0), 32'hFF0000AA);
    check("post_rst_writes", wr_data.size(), 32'd2);

    // Two back-to-back maximum-length packets, req_valid held high.
    clear_logs();
    for (int i = 0; i < 512; i++) push_word(32'hB0000000 + i);
    base = acc_q.size();
    @(posedge wrclock);
    #1;
    req_type  = 3'd2;
    req_len   = 9'd256;
    req_valid = 1'b1;
    n = 0;
    while (acc_q.size() < base + 2 && n < 1000) begin
      @(negedge wrclock);
      n++;
    end
    check_bit("b2b_second_accept", n < 1000, 1'b1);
    @(posedge wrclock);
    #1;
    req_valid = 1'b0;
    wait_done(1000);
    check("b2b_writes", wr_data.size(), 32'd514);
    check("b2b_accept_spacing",
          (acc_q.size() >= base + 2) ? acc_q[base + 1] - acc_q[base] : -1,
          32'd260);
    check("b2b_a_span", wc(256) - wc(0), 32'd256);
    // Header B strobe lands 4 cycles after A's last payload strobe.
    check("b2b_gap", wc(257) - wc(256), 32'd4);
    check("b2b_b_hdr", wd(257), 32'hFF000AAA);
    check("b2b_b_last", wd(513), 32'hB00001FF);
    check("b2b_pktends", pe_cyc.size(), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
